// File: rtl/key_repeat_ctrl.sv
// Typematic key repeat scheduler. A make loads the held code and starts the
// initial delay; each vsync falling edge counts one frame. Expiry emits a
// repeat and reloads the rate period. Codes go out through a single-entry
// valid/ready buffer.
module key_repeat_ctrl #(
  parameter int DELAY_FRAMES = 30,
  parameter int RATE_FRAMES  = 4,
  parameter int CODE_W       = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              vsync,
  input  logic              keyValid,
  input  logic [CODE_W-1:0] keyCode,
  input  logic              keyBreak,
  output logic              outValid,
  output logic [CODE_W-1:0] outCode,
  input  logic              outReady,
  output logic              repeating
);

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} state_t;

  localparam logic [7:0] DELAY_CNT = 8'(DELAY_FRAMES);
  localparam logic [7:0] RATE_CNT  = 8'(RATE_FRAMES);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [CODE_W-1:0]   held_q, held_d;
  logic                vsync_q;
  logic                out_valid_q, out_valid_d;
  logic [CODE_W-1:0]   out_code_q, out_code_d;

  logic tick, make_ev, brk_ev, accept;
  logic make_emit, rep_emit;

  assign tick    = vsync_q & ~vsync;
  assign make_ev = keyValid & ~keyBreak & en;
  assign brk_ev  = keyValid & keyBreak & en;
  assign accept  = out_valid_q & outReady;

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      held_q      <= '0;
      vsync_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      vsync_q     <= vsync;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
    end
  end

  // Next state: key events take priority over a same-cycle tick, which is
  // then simply lost. An unmatched break is ignored outright, so a tick in
  // that cycle still counts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    held_d    = held_q;
    make_emit = 1'b0;
    rep_emit  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (make_ev) begin
            held_d    = keyCode;
            cnt_d     = DELAY_CNT;
            make_emit = 1'b1;
            state_d   = DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (make_ev) begin
            held_d    = keyCode;
            cnt_d     = DELAY_CNT;
            make_emit = 1'b1;
            state_d   = DELAY;
          end else if (brk_ev && keyCode == held_q) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (tick) begin
            if (cnt_q > 8'd1) begin
              cnt_d = cnt_q - 8'd1;
            end else if (cnt_q == 8'd1) begin
              rep_emit = 1'b1;
              cnt_d    = RATE_CNT;
              state_d  = REPEAT;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output buffer: a make always overwrites; a repeat only lands in a free
  // (or freeing) slot, otherwise it is dropped.
  always_comb begin
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    if (make_emit) begin
      out_valid_d = 1'b1;
      out_code_d  = keyCode;
    end else if (rep_emit && (!out_valid_q || accept)) begin
      out_valid_d = 1'b1;
      out_code_d  = held_q;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    outValid  = out_valid_q;
    outCode   = out_code_q;
    repeating = (state_q == REPEAT);
  end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Directed bench for key_repeat_ctrl with DELAY_FRAMES=3, RATE_FRAMES=2.
module tb_key_repeat_ctrl;

  logic       clk = 1'b0;
  logic       resetn, en, vsync, keyValid, keyBreak, outReady;
  logic [7:0] keyCode;
  logic       outValid, repeating;
  logic [7:0] outCode;

  int checks   = 0;
  int failures = 0;

  key_repeat_ctrl #(.DELAY_FRAMES(3), .RATE_FRAMES(2), .CODE_W(8)) dut (
    .clk(clk), .resetn(resetn), .en(en), .vsync(vsync),
    .keyValid(keyValid), .keyCode(keyCode), .keyBreak(keyBreak),
    .outValid(outValid), .outCode(outCode), .outReady(outReady),
    .repeating(repeating)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one frame tick: vsync rises, then falls; the tick is consumed on the 2nd edge
  task automatic tick();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
  endtask

  task automatic make(input logic [7:0] code);
    keyValid = 1'b1; keyBreak = 1'b0; keyCode = code;
    step();
    keyValid = 1'b0;
  endtask

  task automatic brk(input logic [7:0] code);
    keyValid = 1'b1; keyBreak = 1'b1; keyCode = code;
    step();
    keyValid = 1'b0; keyBreak = 1'b0;
  endtask

  task automatic chk_v(input string tag, input logic v, input logic rep);
    checks++;
    assert (outValid === v) else begin
      failures++;
      $error("FAIL %s outValid got=%b exp=%b", tag, outValid, v);
    end
    checks++;
    assert (repeating === rep) else begin
      failures++;
      $error("FAIL %s repeating got=%b exp=%b", tag, repeating, rep);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] code,
                         input logic rep);
    chk_v(tag, v, rep);
    checks++;
    assert (outCode === code) else begin
      failures++;
      $error("FAIL %s outCode got=%h exp=%h", tag, outCode, code);
    end
  endtask

  initial begin
    resetn = 1'b0; en = 1'b1; vsync = 1'b0; keyValid = 1'b0;
    keyBreak = 1'b0; keyCode = 8'h00; outReady = 1'b1;
    step(); step();
    chk_out("reset", 1'b0, 8'h00, 1'b0);
    resetn = 1'b1;
    step();

    // hold: make then repeats on ticks 3, 5, 7
    make(8'h1C);
    chk_out("t1_make", 1'b1, 8'h1C, 1'b0);
    step();
    chk_v("t1_accepted", 1'b0, 1'b0);
    tick(); chk_v("t1_tick1", 1'b0, 1'b0);
    tick(); chk_v("t1_tick2", 1'b0, 1'b0);
    tick(); chk_out("t1_tick3", 1'b1, 8'h1C, 1'b1);
    tick(); chk_v("t1_tick4", 1'b0, 1'b1);
    tick(); chk_out("t1_tick5", 1'b1, 8'h1C, 1'b1);
    tick(); chk_v("t1_tick6", 1'b0, 1'b1);
    tick(); chk_out("t1_tick7", 1'b1, 8'h1C, 1'b1);
    brk(8'h1C);
    chk_v("t1_break", 1'b0, 1'b0);

    // make, break after 2 ticks: single output only
    make(8'h1C);
    chk_out("t2_make", 1'b1, 8'h1C, 1'b0);
    step();
    tick(); tick();
    brk(8'h1C);
    chk_v("t2_break", 1'b0, 1'b0);
    tick(); tick(); tick(); chk_v("t2_tick3", 1'b0, 1'b0);
    tick(); tick(); chk_v("t2_tick5", 1'b0, 1'b0);

    // restart with a new code
    make(8'h1C);
    step();
    tick(); tick(); tick();
    chk_out("t3_rep1C", 1'b1, 8'h1C, 1'b1);
    tick();
    chk_v("t3_tick4", 1'b0, 1'b1);
    make(8'h32);
    chk_out("t3_make32", 1'b1, 8'h32, 1'b0);
    step();
    brk(8'h1C);
    chk_v("t3_brk_other", 1'b0, 1'b0);
    tick(); tick();
    chk_v("t3_tick2", 1'b0, 1'b0);
    tick();
    chk_out("t3_rep32", 1'b1, 8'h32, 1'b1);
    brk(8'h32);
    chk_v("t3_break32", 1'b0, 1'b0);

    // consumer stalled: repeats dropped, make overwrites, single accept
    outReady = 1'b0;
    make(8'h1C);
    chk_out("t4_make", 1'b1, 8'h1C, 1'b0);
    tick(); tick(); tick();
    chk_out("t4_drop1", 1'b1, 8'h1C, 1'b1);
    tick(); tick();
    chk_out("t4_drop2", 1'b1, 8'h1C, 1'b1);
    make(8'h32);
    chk_out("t4_overwrite", 1'b1, 8'h32, 1'b0);
    outReady = 1'b1;
    step();
    chk_v("t4_accept", 1'b0, 1'b0);
    step();
    chk_v("t4_empty", 1'b0, 1'b0);
    brk(8'h32);

    // make in the same cycle as a tick while in DELAY
    make(8'h11);
    step();
    tick();
    vsync = 1'b1;
    step();
    vsync = 1'b0; keyValid = 1'b1; keyBreak = 1'b0; keyCode = 8'h45;
    step();
    keyValid = 1'b0;
    chk_out("t5_make45", 1'b1, 8'h45, 1'b0);
    step();
    tick(); tick();
    chk_v("t5_tick2", 1'b0, 1'b0);
    tick();
    chk_out("t5_tick3", 1'b1, 8'h45, 1'b1);

    // reset while repeating with a pending code
    resetn = 1'b0;
    step();
    chk_out("t6_reset", 1'b0, 8'h00, 1'b0);
    resetn = 1'b1;
    en = 1'b0;
    make(8'h55);
    chk_out("t6_en0_make", 1'b0, 8'h00, 1'b0);
    tick(); tick(); tick();
    chk_v("t6_en0_ticks", 1'b0, 1'b0);

    // en dropped mid-delay: FSM idles, buffer still drains
    en = 1'b1;
    outReady = 1'b0;
    make(8'h66);
    en = 1'b0;
    step();
    chk_out("t7_en0_hold", 1'b1, 8'h66, 1'b0);
    outReady = 1'b1;
    step();
    chk_v("t7_en0_drain", 1'b0, 1'b0);
    en = 1'b1;
    tick(); tick(); tick();
    chk_v("t7_idle_ticks", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
